// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg: register map, CTRL field positions and address decode shared
// by the performance monitor top and its per-counter slices.
package perf_mon_pkg;

  // Global register byte offsets
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_IRQ_EN = 8'h08;

  // Counter blocks start at CNTR_BASE and repeat every CNTR_STRIDE bytes.
  // Base == stride == 16, so addr[7:4] is the 1-based counter slot.
  localparam int CNTR_BASE   = 16;
  localparam int CNTR_STRIDE = 16;

  // Offsets inside one counter block
  localparam logic [3:0] SUB_SEL = 4'h0;
  localparam logic [3:0] SUB_LO  = 4'h4;
  localparam logic [3:0] SUB_HI  = 4'h8;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_CLR  = 1;
  localparam int CTRL_SNAP = 2;
  localparam int FINI_LSB  = 16;

  localparam logic [1:0] FINI_CODE_DEF = 2'b10;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_STATUS,
    REG_IRQ_EN,
    REG_SEL,
    REG_CNT_LO,
    REG_CNT_HI
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] idx;
  } reg_dec_t;

  // Classify a byte offset; anything unaligned or beyond the last counter is REG_NONE.
  function automatic reg_dec_t reg_decode(input logic [7:0] addr, input int num_cntrs);
    reg_dec_t   d;
    logic [3:0] slot;
    slot   = addr[7:4];
    d.kind = REG_NONE;
    d.idx  = 3'(slot - 4'd1);
    if (addr == OFF_CTRL)        d.kind = REG_CTRL;
    else if (addr == OFF_STATUS) d.kind = REG_STATUS;
    else if (addr == OFF_IRQ_EN) d.kind = REG_IRQ_EN;
    else if (slot != 4'd0 && int'(slot) <= num_cntrs) begin
      case (addr[3:0])
        SUB_SEL: d.kind = REG_SEL;
        SUB_LO:  d.kind = REG_CNT_LO;
        SUB_HI:  d.kind = REG_CNT_HI;
        default: d.kind = REG_NONE;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/perf_mon_unit_cntr.sv
// perf_mon_cntr: one programmable event counter with its event select.
// Update priority: clear > half-word write > increment.
module perf_mon_cntr
  import perf_mon_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int CNTR_W     = 64,
  parameter int SEL_W      = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
  parameter int HI_W       = CNTR_W - 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [NUM_EVENTS-1:0] ev_i,
  input  logic                  sel_we_i,
  input  logic                  lo_we_i,
  input  logic                  hi_we_i,
  input  logic [31:0]           lo_data_i,
  input  logic [HI_W-1:0]       hi_data_i,
  output logic [CNTR_W-1:0]     cnt_o,
  output logic [SEL_W-1:0]      sel_o,
  output logic                  wrap_o
);

  localparam int EV_PAD = 1 << SEL_W;

  logic [CNTR_W-1:0] cnt_q;
  logic [SEL_W-1:0]  sel_q;
  logic [EV_PAD-1:0] ev_pad;
  logic              inc;

  // Pad the event vector so select codes past NUM_EVENTS see a quiet line
  always_comb begin
    ev_pad                 = '0;
    ev_pad[NUM_EVENTS-1:0] = ev_i;
  end

  assign inc    = en_i && ev_pad[sel_q];
  // Wrap only counts when the increment actually lands
  assign wrap_o = inc && !clr_i && !lo_we_i && !hi_we_i && (&cnt_q);

  // Counter and select state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      if (sel_we_i) sel_q <= lo_data_i[SEL_W-1:0];
      if (clr_i)        cnt_q              <= '0;
      else if (lo_we_i) cnt_q[31:0]        <= lo_data_i;
      else if (hi_we_i) cnt_q[CNTR_W-1:32] <= hi_data_i;
      else if (inc)     cnt_q              <= cnt_q + CNTR_W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign sel_o = sel_q;

endmodule

// File: rtl/perf_mon_unit.sv
// perf_mon_unit: memory-mapped performance monitor. NUM_CNTRS programmable
// counters, sticky overflow status with interrupt mask, tear-free 64-bit
// reads through a hi-latch, and a sticky finish flag.
// Optional macro PERF_MON_SNAPSHOT_EN: CTRL.SNAP copies all counters into
// shadow registers that the CNT offsets then read (hi-latch bypassed).
module perf_mon_unit
  import perf_mon_pkg::*;
#(
  parameter int         NUM_EVENTS = 8,
  parameter int         NUM_CNTRS  = 4,
  parameter int         CNTR_W     = 64,
  parameter logic [1:0] FINI_CODE  = FINI_CODE_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVENTS-1:0] ev_i,
  input  logic                  bus_we_i,
  input  logic                  bus_re_i,
  input  logic [7:0]            bus_addr_i,
  input  logic [31:0]           bus_wdata_i,
  output logic [31:0]           bus_rdata_o,
  output logic                  bus_rvalid_o,
  output logic                  irq_o,
  output logic                  fini_o
);

  localparam int SEL_W = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
  localparam int HI_W  = CNTR_W - 32;

  reg_dec_t dec;
  logic     ctrl_we, status_we, irq_en_we, clr, cnt_en;
  logic     en_q, fini_q;
  logic [1:0] fini_fld_q;
  logic [NUM_CNTRS-1:0] sel_we, lo_we, hi_we, wrap;
  logic [NUM_CNTRS-1:0] status_q, irq_en_q;
  logic [NUM_CNTRS-1:0][CNTR_W-1:0] cnt, rd_cnt;
  logic [NUM_CNTRS-1:0][SEL_W-1:0]  sel;
  logic [31:0] cur_lo, cur_hi, rd_val, rdata_q;
  logic [SEL_W-1:0] cur_sel;
  logic rvalid_q;

  assign dec = reg_decode(bus_addr_i, NUM_CNTRS);

  // Write strobes per register
  always_comb begin
    ctrl_we   = bus_we_i && dec.kind == REG_CTRL;
    status_we = bus_we_i && dec.kind == REG_STATUS;
    irq_en_we = bus_we_i && dec.kind == REG_IRQ_EN;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      sel_we[i] = bus_we_i && dec.kind == REG_SEL    && dec.idx == 3'(i);
      lo_we[i]  = bus_we_i && dec.kind == REG_CNT_LO && dec.idx == 3'(i);
      hi_we[i]  = bus_we_i && dec.kind == REG_CNT_HI && dec.idx == 3'(i);
    end
  end

  assign clr    = ctrl_we && bus_wdata_i[CTRL_CLR];
  assign cnt_en = en_q && !fini_q;

  for (genvar g = 0; g < NUM_CNTRS; g++) begin : g_cntr
    perf_mon_cntr #(
      .NUM_EVENTS (NUM_EVENTS),
      .CNTR_W     (CNTR_W),
      .SEL_W      (SEL_W),
      .HI_W       (HI_W)
    ) u_cntr (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (cnt_en),
      .clr_i     (clr),
      .ev_i      (ev_i),
      .sel_we_i  (sel_we[g]),
      .lo_we_i   (lo_we[g]),
      .hi_we_i   (hi_we[g]),
      .lo_data_i (bus_wdata_i),
      .hi_data_i (bus_wdata_i[HI_W-1:0]),
      .cnt_o     (cnt[g]),
      .sel_o     (sel[g]),
      .wrap_o    (wrap[g])
    );
  end

  // CTRL fields and the sticky finish flag
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      en_q       <= 1'b0;
      fini_fld_q <= 2'b00;
      fini_q     <= 1'b0;
    end else if (ctrl_we) begin
      en_q       <= bus_wdata_i[CTRL_EN];
      fini_fld_q <= bus_wdata_i[FINI_LSB +: 2];
      if (bus_wdata_i[FINI_LSB +: 2] == FINI_CODE) fini_q <= 1'b1;
    end
  end

  // Overflow status (wrap wins over W1C) and interrupt mask
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      status_q <= '0;
      irq_en_q <= '0;
    end else begin
      status_q <= (status_q & ~(status_we ? bus_wdata_i[NUM_CNTRS-1:0] : '0)) | wrap;
      if (irq_en_we) irq_en_q <= bus_wdata_i[NUM_CNTRS-1:0];
    end
  end

`ifdef PERF_MON_SNAPSHOT_EN
  logic [NUM_CNTRS-1:0][CNTR_W-1:0] shadow_q;

  // Shadow copy; captures pre-clear values when SNAP and CLR coincide
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                               shadow_q <= '0;
    else if (ctrl_we && bus_wdata_i[CTRL_SNAP]) shadow_q <= cnt;
  end

  assign rd_cnt = shadow_q;
`else
  logic [31:0] hi_lat_q;
  logic        lat_vld_q;
  logic [2:0]  lat_idx_q;

  assign rd_cnt = cnt;

  // Hi-latch: armed by a lo read, consumed or dropped by any later read
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hi_lat_q  <= '0;
      lat_vld_q <= 1'b0;
      lat_idx_q <= '0;
    end else if (bus_re_i) begin
      lat_vld_q <= dec.kind == REG_CNT_LO;
      lat_idx_q <= dec.idx;
      if (dec.kind == REG_CNT_LO) hi_lat_q <= cur_hi;
    end
  end
`endif

  // Fields of the counter addressed by the current offset
  always_comb begin
    cur_lo  = '0;
    cur_hi  = '0;
    cur_sel = '0;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      if (dec.idx == 3'(i)) begin
        cur_lo             = rd_cnt[i][31:0];
        cur_hi[HI_W-1:0]   = rd_cnt[i][CNTR_W-1:32];
        cur_sel            = sel[i];
      end
    end
  end

  // Read data mux; reflects pre-write state when a write shares the cycle
  always_comb begin
    rd_val = '0;
    case (dec.kind)
      REG_CTRL: begin
        rd_val[CTRL_EN]       = cnt_en;
        rd_val[FINI_LSB +: 2] = fini_fld_q;
      end
      REG_STATUS: rd_val[NUM_CNTRS-1:0] = status_q;
      REG_IRQ_EN: rd_val[NUM_CNTRS-1:0] = irq_en_q;
      REG_SEL:    rd_val[SEL_W-1:0]     = cur_sel;
      REG_CNT_LO: rd_val = cur_lo;
      REG_CNT_HI: begin
        rd_val = cur_hi;
`ifndef PERF_MON_SNAPSHOT_EN
        if (lat_vld_q && lat_idx_q == dec.idx) rd_val = hi_lat_q;
`endif
      end
      default: rd_val = '0;
    endcase
  end

  // One-cycle read response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= bus_re_i ? rd_val : '0;
      rvalid_q <= bus_re_i;
    end
  end

  assign bus_rdata_o  = rdata_q;
  assign bus_rvalid_o = rvalid_q;
  assign irq_o        = |(status_q & irq_en_q);
  assign fini_o       = fini_q;

endmodule

// File: tb/tb_perf_mon_unit.sv
// tb_perf_mon_unit: directed plan plus randomized traffic, checked every
// cycle against a register-level reference model of the monitor.
// Honours PERF_MON_SNAPSHOT_EN the same way as the design.
module tb_perf_mon_unit;

  localparam int         NE = 8;
  localparam int         NC = 4;
  localparam int         CW = 64;
  localparam logic [1:0] FC = 2'b10;
  localparam logic [63:0] CMASK = (CW == 64) ? {64{1'b1}} : ((64'd1 << CW) - 64'd1);
  localparam int         SELMASK = (1 << $clog2(NE)) - 1;

  logic          clk = 1'b0;
  logic          rst_n, we, re;
  logic [NE-1:0] ev;
  logic [7:0]    addr;
  logic [31:0]   wdata, rdata, d;
  logic          rvalid, irq, fini;

  always #5 clk = ~clk;

  perf_mon_unit #(.NUM_EVENTS(NE), .NUM_CNTRS(NC), .CNTR_W(CW), .FINI_CODE(FC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ev_i(ev), .bus_we_i(we), .bus_re_i(re),
    .bus_addr_i(addr), .bus_wdata_i(wdata), .bus_rdata_o(rdata),
    .bus_rvalid_o(rvalid), .irq_o(irq), .fini_o(fini)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;

  // Reference model state
  longint unsigned m_cnt[NC];
  longint unsigned m_snap[NC];
  int              m_sel[NC];
  logic [NC-1:0]   m_status, m_irqen;
  bit              m_en, m_fini, m_lat_v;
  logic [1:0]      m_fld;
  int              m_lat_i;
  longint unsigned m_lat_hi;
  bit              exp_rv;
  logic [31:0]     exp_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic longint unsigned m_src(input int i);
`ifdef PERF_MON_SNAPSHOT_EN
    return m_snap[i];
`else
    return m_cnt[i];
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    logic [31:0] r;
    int slot, i;
    r    = '0;
    slot = int'(a[7:4]);
    i    = slot - 1;
    if (a == 8'h00) begin
      r[0]     = m_en && !m_fini;
      r[17:16] = m_fld;
    end else if (a == 8'h04) r[NC-1:0] = m_status;
    else if (a == 8'h08)     r[NC-1:0] = m_irqen;
    else if (slot >= 1 && i < NC) begin
      if (a[3:0] == 4'h0) r = 32'(m_sel[i]);
      else if (a[3:0] == 4'h4) r = 32'(m_src(i) & 64'hFFFF_FFFF);
      else if (a[3:0] == 4'h8) begin
        r = 32'(m_src(i) >> 32);
`ifndef PERF_MON_SNAPSHOT_EN
        if (m_lat_v && m_lat_i == i) r = 32'(m_lat_hi);
`endif
      end
    end
    return r;
  endfunction

  // Advance the model by one clock using the inputs now on the pins, then check
  task automatic cycle();
    logic [NC-1:0] wrap;
    bit cnt_on, clr, ctrl_w;
    int slot;
    wrap = '0;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin m_cnt[i] = 0; m_snap[i] = 0; m_sel[i] = 0; end
      m_status = '0; m_irqen = '0; m_en = 0; m_fini = 0; m_fld = '0;
      m_lat_v = 0; m_lat_i = 0; m_lat_hi = 0; exp_rv = 0;
    end else begin
      exp_rv = re;
      if (re) begin
        exp_rd = m_read(addr);
        slot   = int'(addr[7:4]);
        m_lat_v = (slot >= 1 && slot <= NC && addr[3:0] == 4'h4);
        if (m_lat_v) begin
          m_lat_i  = slot - 1;
          m_lat_hi = m_cnt[slot-1] >> 32;
        end
      end
      cnt_on = m_en && !m_fini;
      ctrl_w = we && addr == 8'h00;
      clr    = ctrl_w && wdata[1];
`ifdef PERF_MON_SNAPSHOT_EN
      if (ctrl_w && wdata[2]) for (int i = 0; i < NC; i++) m_snap[i] = m_cnt[i];
`endif
      for (int i = 0; i < NC; i++) begin
        if (clr) m_cnt[i] = 0;
        else if (we && addr == 8'(20 + 16*i))
          m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF) | 64'(wdata);
        else if (we && addr == 8'(24 + 16*i))
          m_cnt[i] = ((m_cnt[i] & 64'hFFFF_FFFF) | (64'(wdata) << 32)) & CMASK;
        else if (cnt_on && m_sel[i] < NE && ev[m_sel[i]]) begin
          m_cnt[i] = (m_cnt[i] + 1) & CMASK;
          if (m_cnt[i] == 0) wrap[i] = 1'b1;
        end
        if (we && addr == 8'(16 + 16*i)) m_sel[i] = int'(wdata) & SELMASK;
      end
      if (we && addr == 8'h04) m_status = m_status & ~wdata[NC-1:0];
      m_status = m_status | wrap;
      if (we && addr == 8'h08) m_irqen = wdata[NC-1:0];
      if (ctrl_w) begin
        m_en  = wdata[0];
        m_fld = wdata[17:16];
        if (wdata[17:16] == FC) m_fini = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("rvalid", rvalid, exp_rv);
    if (exp_rv) chk("rdata", rdata, exp_rd);
    chk("irq", irq, |(m_status & m_irqen));
    chk("fini", fini, m_fini);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    we = 1'b1; addr = a; wdata = v;
    cycle();
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    re = 1'b1; addr = a;
    cycle();
    v  = rdata;
    re = 1'b0;
  endtask

  // In the snapshot build, refresh the shadows so counter reads see live values
  task automatic sync_snap();
`ifdef PERF_MON_SNAPSHOT_EN
    wr(8'h00, 32'h5);
`endif
  endtask

  initial begin
    logic [31:0] wd;
    logic [7:0]  a;
    int          op;
    rst_n = 1'b0; ev = '0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    cycle(); cycle();
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    rd(8'h00, d); chk("rst_ctrl", d, 0);

    // Count 100 events on line 2, tear-free hi read
    wr(8'h10, 32'd2); wr(8'h00, 32'd1);
    ev = 8'h04; repeat (100) cycle(); ev = '0;
    wr(8'h00, 32'd0);
    sync_snap();
    rd(8'h14, d); chk("cnt0_lo", d, 100);
    wr(8'h18, 32'h0000_1234);
    rd(8'h18, d); chk("cnt0_hi_latched", d, 0);
    rd(8'h18, d);
`ifdef PERF_MON_SNAPSHOT_EN
    chk("cnt0_hi_shadow", d, 0);
`else
    chk("cnt0_hi_live", d, 32'h1234);
`endif
    wr(8'h18, 32'd0);

    // Wrap and interrupt on counter 1
    wr(8'h20, 32'd3); wr(8'h24, 32'hFFFF_FFFE); wr(8'h28, 32'hFFFF_FFFF);
    wr(8'h08, 32'h2); wr(8'h00, 32'd1);
    ev = 8'h08; cycle(); ev = '0; cycle(); ev = 8'h08; cycle(); ev = '0;
    chk("wrap_irq", irq, 1);
    rd(8'h04, d); chk("wrap_status", d, 32'h2);
    sync_snap();
    rd(8'h24, d); chk("wrap_lo", d, 0);
    rd(8'h28, d); chk("wrap_hi", d, 0);
    wr(8'h04, 32'h2); chk("w1c_irq", irq, 0);

    // Write vs event, then CLR vs event
    wr(8'h00, 32'd1);
    ev = 8'h04; wr(8'h14, 32'd5); ev = '0;
    sync_snap();
    rd(8'h14, d); chk("wr_beats_inc", d, 5);
    ev = 8'hFF; wr(8'h00, 32'h3); ev = '0;
    sync_snap();
    rd(8'h14, d); chk("clr_cnt0", d, 0);
    rd(8'h24, d); chk("clr_cnt1", d, 0);

    // Randomized traffic
    wr(8'h00, 32'd1);
    for (int k = 0; k < 800; k++) begin
      ev = NE'($urandom);
      op = $urandom_range(0, 9);
      a  = 8'(4 * $urandom_range(0, 39));
      wd = $urandom;
      if (op == 5) begin
        a  = 8'(20 + 16 * $urandom_range(0, NC-1) + 4 * $urandom_range(0, 1));
        wd = (a[3:0] == 4'h4) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'hFFFF_FFFF;
      end
      if (op == 8) a = 8'h00;
      if (a == 8'h00) begin
        if (wd[17:16] == FC) wd[16] = ~wd[16];
        wd[1] = ($urandom_range(0, 7) == 0);
        wd[0] = ($urandom_range(0, 3) != 0);
      end
      addr = a; wdata = wd;
      re = (op <= 4);
      we = (op == 4) || (op >= 5 && op <= 8);
      cycle();
      we = 1'b0; re = 1'b0;
    end

`ifdef PERF_MON_SNAPSHOT_EN
    // Snapshot holds 40 while live count moves to 50
    wr(8'h00, 32'h2); wr(8'h10, 32'd2); wr(8'h00, 32'd1);
    ev = 8'h04; repeat (40) cycle(); ev = '0;
    wr(8'h00, 32'h5);
    ev = 8'h04; repeat (10) cycle(); ev = '0;
    rd(8'h14, d); chk("snap_held", d, 40);
    wr(8'h00, 32'h5);
    rd(8'h14, d); chk("snap_live", d, 50);
`endif

    // Finish stops counting and masks EN
    wr(8'h10, 32'd0); wr(8'h00, 32'h2);
    wr(8'h00, 32'h0002_0001);
    chk("fini_set", fini, 1);
    ev = 8'hFF; repeat (5) cycle(); ev = '0;
    rd(8'h00, d); chk("fini_ctrl", d, 32'h0002_0000);
    sync_snap();
    rd(8'h14, d); chk("fini_frozen", d, 0);
    chk("fini_sticky", fini, 1);

    // Reset mid-count with a read in flight
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    wr(8'h00, 32'd1);
    ev = 8'hFF; repeat (7) cycle();
    re = 1'b1; addr = 8'h14; rst_n = 1'b0; cycle(); re = 1'b0; rst_n = 1'b1;
    chk("mid_rst_rvalid", rvalid, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_fini", fini, 0);
    repeat (5) cycle(); ev = '0;
    sync_snap();
    rd(8'h14, d); chk("mid_rst_idle", d, 0);
    wr(8'h00, 32'd1);
    ev = 8'hFF; repeat (3) cycle(); ev = '0;
    sync_snap();
    rd(8'h14, d); chk("mid_rst_resume", d, 3);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/perf_mon_unit.md
Name: perf_mon_unit

Overview:
- Synthesizable, memory-mapped hardware performance monitor. Parametrised successor to the fixed cycle/instret/branch counters in the simulation top.
- NUM_CNTRS counters, each programmable to count any one of NUM_EVENTS event lines from the CPU (valid-retire, ctrl-transfer, mispredict, stall, ...).
- Adds a sticky finish flag set by software, overflow status and an interrupt.
- Sits on the CPU data bus beside the other MMIO peripherals.

Parameters:
- NUM_EVENTS, 8, width of the event input vector.
- NUM_CNTRS, 4, number of programmable counters (1..8).
- CNTR_W, 64, counter width (33..64); bits above CNTR_W read as 0.
- FINI_CODE, 2'b10, CTRL[17:16] value that raises fini_o.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, synchronous, active-low.
- ev_i  in  NUM_EVENTS  event pulses; sampled every cycle, one count per asserted cycle.
- bus_we_i  in  1  write strobe, single cycle.
- bus_re_i  in  1  read strobe, single cycle.
- bus_addr_i  in  8  byte offset within the block, word aligned.
- bus_wdata_i  in  32  write data.
- bus_rdata_o  out  32  read data, valid while bus_rvalid_o=1.
- bus_rvalid_o  out  1  read-data valid, exactly one cycle after bus_re_i.
- irq_o  out  1  level interrupt: |(STATUS & IRQ_EN).
- fini_o  out  1  sticky finish flag, used by the bench to end simulation.

Behaviour:
- Reset (rst_ni=0 at posedge): all counters, SEL, STATUS, IRQ_EN, CTRL and latches cleared; bus_rdata_o=0, bus_rvalid_o=0, irq_o=0, fini_o=0.
- Register map, byte offsets:
  - 0x00 CTRL: bit0 EN (global count enable); bit1 CLR (write-1 clears all counters, self-clearing, reads 0); bit2 SNAP (see optional feature); [17:16] FINI field.
  - 0x04 STATUS: per-counter overflow bits, write-1-to-clear.
  - 0x08 IRQ_EN: per-counter interrupt mask.
  - 0x10+16*i: SEL_i, low clog2(NUM_EVENTS) bits used.
  - 0x14+16*i: CNT_i[31:0].
  - 0x18+16*i: CNT_i[63:32].
  - Unmapped offsets read 0; writes to them are ignored.
- Counting: each cycle, if EN and ev_i[SEL_i], CNT_i <= CNT_i+1, modulo 2^CNTR_W.
- Wrap: when CNT_i wraps from all-ones to 0, STATUS[i] is set in the same cycle.
- Priority for counter i in one cycle: CLR > bus write to CNT_i > increment. A written value is not incremented that cycle.
- STATUS priority: set-by-wrap beats W1C in the same cycle.
- Writing a counter half replaces only that half; no carry crosses into the other half on a write.
- Tear-free 64-bit read:
  - Reading CNT_i lo latches CNT_i hi into a hi-latch.
  - The next read of CNT_i hi returns the latch if no other register was read in between; otherwise it returns the live value.
- Read latency: one cycle. Reads have no side effects other than the hi-latch.
- Finish:
  - A CTRL write with wdata[17:16]==FINI_CODE sets fini_o on the next cycle; it is sticky until reset.
  - fini_o=1 forces EN to read back 0, and counting stops.
- Simultaneous bus_we_i and bus_re_i: the write is performed; the read returns the pre-write value.
- Reset asserted mid-operation: everything returns to reset state on that edge. No pending read completes.

Optional Feature:
- Macro: PERF_MON_SNAPSHOT_EN.
- Defined:
  - Writing CTRL.SNAP=1 copies all counters into shadow registers in one cycle.
  - CNT offsets read the shadow registers; writes still target the live counters.
  - The hi-latch is bypassed.
  - A snapshot in the same cycle as CLR captures the pre-clear values.
- Undefined: SNAP is ignored and reads 0; no shadow storage is built.

Decomposition:
- Shared package perf_mon_pkg: register offset constants, CTRL bit positions, FINI field position and default FINI_CODE, counter-stride constant.
- Sub-module perf_mon_cntr, one instance per counter:
  - holds CNTR_W counter and SEL;
  - implements increment, write-half and clear priority;
  - outputs a wrap pulse.
- Top: bus decode, STATUS/IRQ, hi-latch, finish flag, optional shadows.

Test Plan:
- Count and tear-free read: SEL_0=2, EN=1, hold ev_i[2]=1 for 100 cycles, EN=0 → CNT_0 lo=100, hi=0; a hi read after the lo read returns the latched hi.
- Wrap and interrupt: write CNT_1 = 0xFFFF_FFFF_FFFF_FFFE, IRQ_EN=0x2, pulse ev twice → CNT_1=0, STATUS=0x2, irq_o=1. W1C 0x2 → irq_o=0.
- Collisions: bus write CNT_0 lo=5 in the same cycle as an event → CNT_0=5. CLR with a simultaneous event → all counters 0.
- Finish: CTRL write 0x0002_0001 → fini_o=1 next cycle; further events do not count; CTRL reads EN=0; fini_o holds until rst_ni=0.
- Mid-count reset: rst_ni=0 for one edge while counting → all outputs 0 and bus_rvalid_o=0; counting resumes only after EN is rewritten.
- Snapshot (PERF_MON_SNAPSHOT_EN): snapshot at a count of 40, then 10 more events → reads return 40; live value is 50 after a second snapshot.
